// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types and pin levels for the SRAM bus arbiter.
// FSM states, grant encoding, data width and inactive SRAM pin levels.
package sram_bus_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = DATA_W / 8;
    localparam int CNT_W  = 4;

    localparam logic             CE_N_IDLE = 1'b1;
    localparam logic             WE_N_IDLE = 1'b1;
    localparam logic [SEL_W-1:0] BE_N_IDLE = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// Bus bundle between the openmips fetch/load-store ports, the arbiter and the SRAM pads.
// Signal names and directions are given from the arbiter's point of view.
interface sram_bus_arbiter_if
    import sram_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 20
) ();

    logic              if_req_i;
    logic [31:0]       if_addr_i;
    logic [DATA_W-1:0] if_data_o;
    logic              if_ready_o;

    logic              mem_req_i;
    logic              mem_we_i;
    logic [SEL_W-1:0]  mem_sel_i;
    logic [31:0]       mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic [DATA_W-1:0] mem_rdata_o;
    logic              mem_ready_o;

    logic              stallreq_o;

    logic              sram_ce_n_o;
    logic              sram_we_n_o;
    logic [SEL_W-1:0]  sram_be_n_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [DATA_W-1:0] sram_dq_o;
    logic              sram_dq_oe_o;
    logic [DATA_W-1:0] sram_dq_i;

    modport slave (
        input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
               sram_dq_i,
        output if_data_o, if_ready_o, mem_rdata_o, mem_ready_o, stallreq_o,
               sram_ce_n_o, sram_we_n_o, sram_be_n_o, sram_addr_o, sram_dq_o, sram_dq_oe_o
    );

    modport master (
        output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
               sram_dq_i,
        input  if_data_o, if_ready_o, mem_rdata_o, mem_ready_o, stallreq_o,
               sram_ce_n_o, sram_we_n_o, sram_be_n_o, sram_addr_o, sram_dq_o, sram_dq_oe_o
    );

endinterface

// File: rtl/sram_bus_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one external 32-bit SRAM,
// with WAIT_CYCLES extra cycles per access and a combinational stall request.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    sram_bus_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES);

    state_t            r_state, w_state_nxt;
    grant_t            r_grant, w_grant_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              w_grant_en;
    logic              w_last_beat;

    logic              w_lat_mem;
    logic              w_lat_store;
    logic [ADDR_W-1:0] w_lat_waddr;
    logic [SEL_W-1:0]  w_lat_be_n;
    logic              w_unused_addr_bits;

    logic              r_store;
    logic              r_ce_n;
    logic              r_we_n;
    logic [SEL_W-1:0]  r_be_n;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dq_o;
    logic              r_dq_oe;
    logic [DATA_W-1:0] r_if_data;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_if_ready;
    logic              r_mem_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
        w_grant_en  = 1'b0;
        w_last_beat = (r_state == ST_ACCESS) && (r_cnt == LAST);
        case (r_state)
            ST_IDLE: begin
                if (bus.if_req_i || bus.mem_req_i) begin
                    w_grant_en  = 1'b1;
                    w_state_nxt = ST_ACCESS;
                    w_cnt_nxt   = '0;
                    if (bus.if_req_i && bus.mem_req_i)
                        w_grant_nxt = (r_grant == GRANT_IF) ? GRANT_MEM : GRANT_IF;
                    else
                        w_grant_nxt = bus.mem_req_i ? GRANT_MEM : GRANT_IF;
                end
            end
            ST_ACCESS: begin
                if (w_last_beat) w_state_nxt = ST_DONE;
                else             w_cnt_nxt   = r_cnt + 1'b1;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // r_grant doubles as last_grant: it is only rewritten on a grant edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_grant <= GRANT_IF;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_lat_mem   = (w_grant_nxt == GRANT_MEM);
    assign w_lat_store = w_lat_mem & bus.mem_we_i;
    assign w_lat_waddr = w_lat_mem ? bus.mem_addr_i[ADDR_W+1:2] : bus.if_addr_i[ADDR_W+1:2];
    assign w_lat_be_n  = w_lat_mem ? ~bus.mem_sel_i : '0;
    assign w_unused_addr_bits = ^{bus.if_addr_i[1:0], bus.if_addr_i[31:ADDR_W+2],
                                  bus.mem_addr_i[1:0], bus.mem_addr_i[31:ADDR_W+2]};

    // Pins are loaded on the edge that enters each phase so they are valid for the whole cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_store     <= 1'b0;
            r_ce_n      <= CE_N_IDLE;
            r_we_n      <= WE_N_IDLE;
            r_be_n      <= BE_N_IDLE;
            r_addr      <= '0;
            r_dq_o      <= '0;
            r_dq_oe     <= 1'b0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
        end else begin
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            if (w_grant_en) begin
                r_store <= w_lat_store;
                r_addr  <= w_lat_waddr;
                r_be_n  <= w_lat_be_n;
                r_ce_n  <= 1'b0;
                r_we_n  <= ~w_lat_store;
                r_dq_oe <= w_lat_store;
                if (w_lat_mem) r_dq_o <= bus.mem_wdata_i;
            end else if (w_last_beat) begin
                r_ce_n  <= CE_N_IDLE;
                r_we_n  <= WE_N_IDLE;
                r_be_n  <= BE_N_IDLE;
                r_dq_oe <= 1'b0;
                if (r_grant == GRANT_IF) begin
                    r_if_data  <= bus.sram_dq_i;
                    r_if_ready <= 1'b1;
                end else begin
                    if (!r_store) r_mem_rdata <= bus.sram_dq_i;
                    r_mem_ready <= 1'b1;
                end
            end else if (r_state == ST_ACCESS && w_cnt_nxt == LAST) begin
                r_we_n <= WE_N_IDLE;
            end
        end
    end

    assign bus.stallreq_o   = (bus.if_req_i & ~r_if_ready) | (bus.mem_req_i & ~r_mem_ready);
    assign bus.if_data_o    = r_if_data;
    assign bus.if_ready_o   = r_if_ready;
    assign bus.mem_rdata_o  = r_mem_rdata;
    assign bus.mem_ready_o  = r_mem_ready;
    assign bus.sram_ce_n_o  = r_ce_n;
    assign bus.sram_we_n_o  = r_we_n;
    assign bus.sram_be_n_o  = r_be_n;
    assign bus.sram_addr_o  = r_addr;
    assign bus.sram_dq_o    = r_dq_o;
    assign bus.sram_dq_oe_o = r_dq_oe;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench: two arbiters (WAIT_CYCLES=1 and 0) on behavioural SRAMs,
// compared against a transaction-level model of grant order, latency and memory contents.
module tb_sram_bus_arbiter;
    import sram_bus_arbiter_pkg::*;

    localparam int AW = 20;
    localparam int N1 = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_init = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter_if #(.ADDR_W(AW)) b1 ();
    sram_bus_arbiter_if #(.ADDR_W(AW)) b0 ();

    sram_bus_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    sram_bus_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

    logic [31:0] mem1 [256];
    logic [31:0] mem0 [256];
    logic [31:0] sh1  [256];
    logic [31:0] sh0  [256];

    grant_t      last1;
    logic [31:0] exp_if1, exp_rd1;

    function automatic logic [31:0] init_word(input int unsigned i);
        if (i == 4) return 32'h3401_1100;
        return (32'(i) * 32'h0101_0101) ^ 32'h5A00_00C3;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        merge = old;
        for (int b = 0; b < 4; b++) if (sel[b]) merge[8*b +: 8] = nw[8*b +: 8];
    endfunction

    assign b1.sram_dq_i = mem1[b1.sram_addr_o[7:0]];
    assign b0.sram_dq_i = mem0[b0.sram_addr_o[7:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= init_word(i);
                mem0[i] <= init_word(i);
            end
        end else begin
            if (!b1.sram_ce_n_o && !b1.sram_we_n_o)
                mem1[b1.sram_addr_o[7:0]] <= merge(mem1[b1.sram_addr_o[7:0]], b1.sram_dq_o, ~b1.sram_be_n_o);
            if (!b0.sram_ce_n_o && !b0.sram_we_n_o)
                mem0[b0.sram_addr_o[7:0]] <= merge(mem0[b0.sram_addr_o[7:0]], b0.sram_dq_o, ~b0.sram_be_n_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] rd, output int lat);
        b1.mem_we_i = we; b1.mem_sel_i = sel; b1.mem_addr_i = addr; b1.mem_wdata_i = wd;
        b1.mem_req_i = 1'b1;
        lat = -1; rd = 'x;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (b1.mem_ready_o) begin lat = c; rd = b1.mem_rdata_o; break; end
        end
        b1.mem_req_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        b1.if_req_i = 0; b1.mem_req_i = 0; b1.if_addr_i = '0; b1.mem_addr_i = '0;
        b1.mem_we_i = 0; b1.mem_sel_i = '0; b1.mem_wdata_i = '0;
        b0.if_req_i = 0; b0.mem_req_i = 0; b0.if_addr_i = '0; b0.mem_addr_i = '0;
        b0.mem_we_i = 0; b0.mem_sel_i = '0; b0.mem_wdata_i = '0;
        rst = 1'b0; mem_init = 1'b1;
        #195;
        mem_init = 1'b0;
        for (int i = 0; i < 256; i++) begin sh1[i] = init_word(i); sh0[i] = init_word(i); end
        checks++; if (b1.sram_ce_n_o !== 1'b1) begin errors++; $display("FAIL reset_ce_n got=%b exp=1", b1.sram_ce_n_o); end
        checks++; if (b1.sram_we_n_o !== 1'b1) begin errors++; $display("FAIL reset_we_n got=%b exp=1", b1.sram_we_n_o); end
        checks++; if (b1.sram_be_n_o !== 4'hF) begin errors++; $display("FAIL reset_be_n got=%h exp=f", b1.sram_be_n_o); end
        checks++; if ({b1.if_ready_o, b1.mem_ready_o} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", {b1.if_ready_o, b1.mem_ready_o}); end
        checks++; if ({b1.sram_addr_o, b1.sram_dq_o, b1.sram_dq_oe_o} !== '0) begin errors++; $display("FAIL reset_addr_dq got=%h/%h/%b exp=0", b1.sram_addr_o, b1.sram_dq_o, b1.sram_dq_oe_o); end
        checks++; if ({b1.if_data_o, b1.mem_rdata_o} !== 64'd0) begin errors++; $display("FAIL reset_data got=%h/%h exp=0", b1.if_data_o, b1.mem_rdata_o); end
        checks++; if ({b0.sram_ce_n_o, b0.sram_we_n_o, b0.sram_be_n_o} !== 6'h3F) begin errors++; $display("FAIL reset_dut0_pins got=%h exp=3f", {b0.sram_ce_n_o, b0.sram_we_n_o, b0.sram_be_n_o}); end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (b1.sram_ce_n_o !== 1'b1 || b1.stallreq_o !== 1'b0) begin errors++; $display("FAIL post_reset_idle got ce_n=%b stall=%b exp=1/0", b1.sram_ce_n_o, b1.stallreq_o); end
        last1 = GRANT_IF; exp_if1 = '0; exp_rd1 = '0;
    endtask

    task automatic test_contention();
        grant_t first, other, g;
        int k;
        logic exp_any, exp_ir, exp_mr, exp_st;
        first = (last1 == GRANT_IF) ? GRANT_MEM : GRANT_IF;
        other = (first == GRANT_IF) ? GRANT_MEM : GRANT_IF;
        b1.if_addr_i = 32'h20; b1.mem_addr_i = 32'h30; b1.mem_we_i = 0; b1.mem_sel_i = 4'hF;
        b1.if_req_i = 1; b1.mem_req_i = 1;
        for (int c = 1; c <= 4*(N1+2)+1; c++) begin
            tick();
            k = (c - (N1+1)) / (N1+2);
            g = (k % 2 == 0) ? first : other;
            exp_any = (c >= N1+1) && ((c-(N1+1)) % (N1+2) == 0) && (k < 4);
            exp_ir = exp_any && (g == GRANT_IF);
            exp_mr = exp_any && (g == GRANT_MEM);
            exp_st = (b1.if_req_i && !exp_ir) || (b1.mem_req_i && !exp_mr);
            checks++; if (b1.if_ready_o !== exp_ir) begin errors++; $display("FAIL contention_if_ready c=%0d got=%b exp=%b", c, b1.if_ready_o, exp_ir); end
            checks++; if (b1.mem_ready_o !== exp_mr) begin errors++; $display("FAIL contention_mem_ready c=%0d got=%b exp=%b", c, b1.mem_ready_o, exp_mr); end
            checks++; if (b1.stallreq_o !== exp_st) begin errors++; $display("FAIL contention_stall c=%0d got=%b exp=%b", c, b1.stallreq_o, exp_st); end
            if (exp_ir) begin checks++; if (b1.if_data_o !== sh1[8]) begin errors++; $display("FAIL contention_if_data got=%h exp=%h", b1.if_data_o, sh1[8]); end end
            if (exp_mr) begin checks++; if (b1.mem_rdata_o !== sh1[12]) begin errors++; $display("FAIL contention_mem_data got=%h exp=%h", b1.mem_rdata_o, sh1[12]); end end
            if (exp_any && k == 3) begin b1.if_req_i = 0; b1.mem_req_i = 0; end
        end
        b1.if_req_i = 0; b1.mem_req_i = 0;
        last1 = other; exp_if1 = sh1[8]; exp_rd1 = sh1[12];
    endtask

    task automatic test_fetch();
        logic exp_ce, exp_r;
        b1.if_addr_i = 32'h0000_0010; b1.if_req_i = 1;
        #1;
        checks++; if (b1.stallreq_o !== 1'b1 || b1.sram_ce_n_o !== 1'b1) begin errors++; $display("FAIL fetch_req_cycle got stall=%b ce_n=%b exp=1/1", b1.stallreq_o, b1.sram_ce_n_o); end
        for (int c = 1; c <= 4; c++) begin
            tick();
            exp_ce = (c <= N1) ? 1'b0 : 1'b1;
            exp_r  = (c == N1+1);
            checks++; if (b1.sram_ce_n_o !== exp_ce) begin errors++; $display("FAIL fetch_ce_n c=%0d got=%b exp=%b", c, b1.sram_ce_n_o, exp_ce); end
            checks++; if (b1.if_ready_o !== exp_r) begin errors++; $display("FAIL fetch_ready c=%0d got=%b exp=%b", c, b1.if_ready_o, exp_r); end
            if (c <= N1) begin
                checks++; if ({b1.sram_addr_o, b1.sram_be_n_o, b1.sram_we_n_o} !== {20'd4, 4'h0, 1'b1}) begin errors++; $display("FAIL fetch_pins c=%0d got=%h/%h/%b exp=4/0/1", c, b1.sram_addr_o, b1.sram_be_n_o, b1.sram_we_n_o); end
                checks++; if (b1.stallreq_o !== 1'b1) begin errors++; $display("FAIL fetch_stall c=%0d got=%b exp=1", c, b1.stallreq_o); end
            end
            if (exp_r) begin
                checks++; if (b1.stallreq_o !== 1'b0) begin errors++; $display("FAIL fetch_stall_ready got=%b exp=0", b1.stallreq_o); end
                b1.if_req_i = 0;
            end
            if (c >= N1+1) begin checks++; if (b1.if_data_o !== 32'h3401_1100) begin errors++; $display("FAIL fetch_data c=%0d got=%h exp=34011100", c, b1.if_data_o); end end
        end
        last1 = GRANT_IF; exp_if1 = 32'h3401_1100;
    endtask

    task automatic test_store_byte();
        int we_low = 0, oe_hi = 0, lat;
        logic [31:0] rd;
        b1.mem_we_i = 1; b1.mem_sel_i = 4'b0010; b1.mem_addr_i = 32'h24; b1.mem_wdata_i = 32'h0000_AB00;
        b1.mem_req_i = 1;
        for (int c = 1; c <= N1+1; c++) begin
            tick();
            if (c <= N1) begin
                checks++; if ({b1.sram_be_n_o, b1.sram_addr_o, b1.sram_dq_o} !== {4'b1101, 20'd9, 32'h0000_AB00}) begin errors++; $display("FAIL store_pins c=%0d got=%b/%h/%h exp=1101/9/0000ab00", c, b1.sram_be_n_o, b1.sram_addr_o, b1.sram_dq_o); end
            end
            if (b1.sram_we_n_o === 1'b0) we_low++;
            if (b1.sram_dq_oe_o === 1'b1) oe_hi++;
        end
        checks++; if (b1.mem_ready_o !== 1'b1) begin errors++; $display("FAIL store_ready got=%b exp=1", b1.mem_ready_o); end
        checks++; if (b1.mem_rdata_o !== exp_rd1) begin errors++; $display("FAIL store_rdata_held got=%h exp=%h", b1.mem_rdata_o, exp_rd1); end
        b1.mem_req_i = 0;
        tick();
        checks++; if (we_low !== 1) begin errors++; $display("FAIL store_we_cycles got=%0d exp=1", we_low); end
        checks++; if (oe_hi !== N1) begin errors++; $display("FAIL store_oe_cycles got=%0d exp=%0d", oe_hi, N1); end
        sh1[9] = merge(sh1[9], 32'h0000_AB00, 4'b0010);
        checks++; if (mem1[9] !== sh1[9]) begin errors++; $display("FAIL store_sram_word got=%h exp=%h", mem1[9], sh1[9]); end
        mem_access(1'b0, 4'hF, 32'h24, 32'h0, rd, lat);
        checks++; if (lat !== N1+1) begin errors++; $display("FAIL load_latency got=%0d exp=%0d", lat, N1+1); end
        checks++; if (rd[15:8] !== 8'hAB || rd !== sh1[9]) begin errors++; $display("FAIL load_back got=%h exp=%h", rd, sh1[9]); end
        last1 = GRANT_MEM; exp_rd1 = sh1[9];
    endtask

    task automatic test_random();
        bit di, dm, st;
        int unsigned wi, wm;
        logic [3:0] sel;
        logic [31:0] wd, exp_if, exp_rd;
        grant_t first;
        int t_if, t_mem;
        logic exp_ir, exp_mr, exp_st;
        for (int it = 0; it < 40; it++) begin
            di = 1'($urandom_range(0, 1)); dm = 1'($urandom_range(0, 1));
            if (!di && !dm) dm = 1;
            wi = $urandom_range(0, 63); wm = $urandom_range(0, 63);
            st = 1'($urandom_range(0, 1)); sel = 4'($urandom_range(1, 15)); wd = $urandom();
            if (di && dm) first = (last1 == GRANT_IF) ? GRANT_MEM : GRANT_IF;
            else          first = dm ? GRANT_MEM : GRANT_IF;
            t_if  = !di ? -1 : ((first == GRANT_IF)  ? N1+1 : 2*N1+3);
            t_mem = !dm ? -1 : ((first == GRANT_MEM) ? N1+1 : 2*N1+3);
            exp_if = exp_if1; exp_rd = exp_rd1;
            if (di && first == GRANT_IF) exp_if = sh1[wi];
            if (dm) begin
                if (st) sh1[wm] = merge(sh1[wm], wd, sel);
                else    exp_rd = sh1[wm];
            end
            if (di && first == GRANT_MEM) exp_if = sh1[wi];
            last1 = (di && dm) ? ((first == GRANT_IF) ? GRANT_MEM : GRANT_IF) : first;
            b1.if_addr_i  = {10'($urandom), 14'd0, 6'(wi), 2'b00};
            b1.mem_addr_i = {10'($urandom), 14'd0, 6'(wm), 2'b00};
            b1.mem_we_i = st; b1.mem_sel_i = sel; b1.mem_wdata_i = wd;
            b1.if_req_i = di; b1.mem_req_i = dm;
            for (int c = 1; c <= 2*N1+5; c++) begin
                tick();
                if (c == 1) begin
                    if (first == GRANT_IF) b1.if_addr_i = $urandom();
                    else begin b1.mem_addr_i = $urandom(); b1.mem_wdata_i = ~wd; b1.mem_sel_i = ~sel; end
                end
                exp_ir = (c == t_if); exp_mr = (c == t_mem);
                exp_st = (b1.if_req_i && !exp_ir) || (b1.mem_req_i && !exp_mr);
                checks++; if (b1.if_ready_o !== exp_ir) begin errors++; $display("FAIL rand_if_ready it=%0d c=%0d got=%b exp=%b", it, c, b1.if_ready_o, exp_ir); end
                checks++; if (b1.mem_ready_o !== exp_mr) begin errors++; $display("FAIL rand_mem_ready it=%0d c=%0d got=%b exp=%b", it, c, b1.mem_ready_o, exp_mr); end
                checks++; if (b1.stallreq_o !== exp_st) begin errors++; $display("FAIL rand_stall it=%0d c=%0d got=%b exp=%b", it, c, b1.stallreq_o, exp_st); end
                if (exp_ir) begin
                    checks++; if (b1.if_data_o !== exp_if) begin errors++; $display("FAIL rand_if_data it=%0d got=%h exp=%h", it, b1.if_data_o, exp_if); end
                    b1.if_req_i = 0;
                end
                if (exp_mr) begin
                    checks++; if (b1.mem_rdata_o !== exp_rd) begin errors++; $display("FAIL rand_mem_rdata it=%0d got=%h exp=%h", it, b1.mem_rdata_o, exp_rd); end
                    b1.mem_req_i = 0;
                end
            end
            b1.if_req_i = 0; b1.mem_req_i = 0;
            if (dm && st) begin checks++; if (mem1[wm] !== sh1[wm]) begin errors++; $display("FAIL rand_sram_word it=%0d got=%h exp=%h", it, mem1[wm], sh1[wm]); end end
            exp_if1 = exp_if; exp_rd1 = exp_rd;
        end
    endtask

    task automatic test_back_to_back();
        int unsigned w = 20;
        logic exp_ce, exp_r;
        b0.if_addr_i = 32'(w << 2); b0.if_req_i = 1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            exp_ce = (c % 3 == 1 && c <= 10) ? 1'b0 : 1'b1;
            exp_r  = (c % 3 == 2 && c <= 11);
            checks++; if (b0.sram_ce_n_o !== exp_ce) begin errors++; $display("FAIL b2b_ce_n c=%0d got=%b exp=%b", c, b0.sram_ce_n_o, exp_ce); end
            checks++; if (b0.if_ready_o !== exp_r) begin errors++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, b0.if_ready_o, exp_r); end
            if (exp_r) begin
                checks++; if (b0.if_data_o !== sh0[w]) begin errors++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, b0.if_data_o, sh0[w]); end
                w++;
                b0.if_addr_i = 32'(w << 2);
                if (c == 11) b0.if_req_i = 0;
            end
        end
        b0.if_req_i = 0;
    endtask

    task automatic test_reset_mid_store();
        int lat;
        logic [31:0] rd;
        b1.mem_we_i = 1; b1.mem_sel_i = 4'hF; b1.mem_addr_i = 32'h40; b1.mem_wdata_i = 32'hDEAD_BEEF;
        b1.mem_req_i = 1;
        tick();
        checks++; if ({b1.sram_ce_n_o, b1.sram_we_n_o} !== 2'b00) begin errors++; $display("FAIL rststore_active got=%b exp=00", {b1.sram_ce_n_o, b1.sram_we_n_o}); end
        rst = 1'b0;
        #1;
        checks++; if ({b1.sram_ce_n_o, b1.sram_we_n_o, b1.sram_dq_oe_o, b1.sram_be_n_o} !== 7'b1101111) begin errors++; $display("FAIL rststore_pins got=%b exp=1101111", {b1.sram_ce_n_o, b1.sram_we_n_o, b1.sram_dq_oe_o, b1.sram_be_n_o}); end
        b1.mem_req_i = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (b1.mem_ready_o !== 1'b0) begin errors++; $display("FAIL rststore_no_ready c=%0d got=%b exp=0", c, b1.mem_ready_o); end
        end
        checks++; if (mem1[16] !== sh1[16]) begin errors++; $display("FAIL rststore_no_write got=%h exp=%h", mem1[16], sh1[16]); end
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (b1.sram_ce_n_o !== 1'b1) begin errors++; $display("FAIL rststore_idle got=%b exp=1", b1.sram_ce_n_o); end
        mem_access(1'b0, 4'hF, 32'h40, 32'h0, rd, lat);
        checks++; if (lat !== N1+1 || rd !== sh1[16]) begin errors++; $display("FAIL rststore_readback got=%h lat=%0d exp=%h lat=%0d", rd, lat, sh1[16], N1+1); end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_fetch();
        test_store_byte();
        test_random();
        test_back_to_back();
        test_reset_mid_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
